imem_loader: RTL and testbench

Program loader that writes the instruction memory and holds the processor core in reset until the load is complete. It takes a byte stream from a host link over a valid/ready handshake and assembles the bytes into little-endian 32-bit words. It writes those words to consecutive instruction-memory word addresses through a one-cycle write strobe, verifies an XOR checksum, and releases the core's active-low reset only when the load verifies. It is the write-side counterpart of the instruction memory's combinational read port.

---
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Program loader for the instruction memory. A host streams bytes over a
// valid/ready link. The stream carries:
//   - a 16-bit little-endian word count N,
//   - N little-endian 32-bit words,
//   - a 32-bit little-endian checksum equal to the XOR of all N words.
// Each completed word is written to the next instruction-memory word address
// with a one-cycle strobe. The core is held in reset (core_rst = 0) until the
// whole image has arrived and its checksum has matched.
//
// Parameters
//   DEPTH   number of 32-bit words in instruction memory (larger images are
//           rejected before any write)
//   ADDR_W  word-address width, 2**ADDR_W >= DEPTH
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   s_valid    host byte valid
//   s_data     host byte
//   s_ready    loader accepts a byte (registered)
//   restart    level; in DONE/ERR starts a new load
//   mem_we     instruction-memory write strobe, one cycle per word
//   mem_addr   word index being written
//   mem_wdata  assembled word
//   core_rst   active-low core reset, 1 only after a verified load
//   done       load completed and checksum matched
//   error      load rejected (oversize image or checksum mismatch)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  // Image-size limit widened by one bit so the full 16-bit count is compared
  // without truncating either operand.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state;
  logic [15:0] nwords;   // word count N from the header
  logic [15:0] wcnt;     // words written so far in this load
  logic [1:0]  bcnt;     // byte position inside the current word
  logic [23:0] shreg;    // bytes 0..2 of the word being assembled
  logic [31:0] csum;     // running XOR of written words

  logic        xfer;
  logic [31:0] word;
  logic [15:0] n_hdr;
  logic [15:0] wcnt_nx;

  assign xfer    = s_valid && s_ready;
  // Bytes shift in from the top, so after three bytes byte k sits at
  // bits [8k+7:8k]; the fourth byte completes the word on the fly.
  assign word    = {s_data, shreg};
  assign n_hdr   = {s_data, nwords[7:0]};
  assign wcnt_nx = wcnt + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HDR0;
      s_ready   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_rst  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      nwords    <= '0;
      wcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      csum      <= '0;
    end else begin
      mem_we <= 1'b0;

      case (state)
        HDR0: begin
          // Also the path by which s_ready first rises after reset.
          s_ready <= 1'b1;
          if (xfer) begin
            nwords[7:0] <= s_data;
            state       <= HDR1;
          end
        end

        HDR1: begin
          if (xfer) begin
            nwords <= n_hdr;
            if ({1'b0, n_hdr} > DEPTH_L) begin
              state   <= ERR;
              error   <= 1'b1;
              s_ready <= 1'b0;
            end else if (n_hdr == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            bcnt  <= bcnt + 2'd1;
            shreg <= {s_data, shreg[23:8]};
            if (bcnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= wcnt[ADDR_W-1:0];
              mem_wdata <= word;
              csum      <= csum ^ word;
              wcnt      <= wcnt_nx;
              if (wcnt_nx == nwords) begin
                state <= CSUM;
              end
            end
          end
        end

        CSUM: begin
          if (xfer) begin
            bcnt  <= bcnt + 2'd1;
            shreg <= {s_data, shreg[23:8]};
            if (bcnt == 2'd3) begin
              s_ready <= 1'b0;
              if (word == csum) begin
                state    <= DONE;
                done     <= 1'b1;
                core_rst <= 1'b1;
              end else begin
                state <= ERR;
                error <= 1'b1;
              end
            end
          end
        end

        DONE, ERR: begin
          // Memory contents are left alone; only the loader state is cleared.
          if (restart) begin
            state    <= HDR0;
            s_ready  <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            core_rst <= 1'b0;
            wcnt     <= '0;
            bcnt     <= '0;
            csum     <= '0;
          end
        end

        default: begin
          state   <= HDR0;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready;
  logic              restart = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .restart   (restart),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe is logged as {addr, data}.
  logic [47:0] wq[$];
  int cyc = 0;
  int last_we = -100;
  always @(negedge clk) begin
    cyc++;
    if (mem_we === 1'b1) begin
      wq.push_back({16'(mem_addr), mem_wdata});
      check("we_spacing", 64'((cyc - last_we) >= 3), 64'd1);
      last_we = cyc;
    end
  end

  // Image under test.
  logic [31:0] img[$];
  bit noise_restart = 1'b0;

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int g;
    int t;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      s_valid = 1'b0;
      restart = noise_restart ? 1'($urandom_range(1, 0)) : 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    restart = noise_restart ? 1'($urandom_range(1, 0)) : 1'b0;
    t = 0;
    while (s_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      check("ready_timeout", 64'd0, 64'd1);
      s_valid = 1'b0;
      restart = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    restart = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_max);
  endtask

  task automatic fill_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  // Sends a complete frame built from img; the checksum is the XOR of the
  // image words, optionally corrupted by mask. Then compares the outcome
  // with what the framing rules require.
  task automatic load_and_check(input string name, input int n,
                                input logic [31:0] mask, input int gap);
    logic [31:0] x;
    bit ok;
    logic [15:0] n16;
    n16 = 16'(n);
    x = '0;
    wq.delete();
    send_byte(n16[7:0], gap);
    send_byte(n16[15:8], gap);
    if (n > DEPTH) begin
      @(negedge clk);
      check({name, "_error"}, 64'(error), 64'd1);
      check({name, "_done"}, 64'(done), 64'd0);
      check({name, "_core_rst"}, 64'(core_rst), 64'd0);
      check({name, "_s_ready"}, 64'(s_ready), 64'd0);
      check({name, "_nwrites"}, 64'(wq.size()), 64'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      send_word(img[i], gap);
      x ^= img[i];
    end
    send_word(x ^ mask, gap);
    ok = (mask == 32'd0);
    @(negedge clk);
    check({name, "_done"}, 64'(done), 64'(ok));
    check({name, "_core_rst"}, 64'(core_rst), 64'(ok));
    check({name, "_error"}, 64'(error), 64'(!ok));
    check({name, "_s_ready"}, 64'(s_ready), 64'd0);
    check({name, "_nwrites"}, 64'(wq.size()), 64'(n));
    for (int i = 0; i < n && i < wq.size(); i++)
      check($sformatf("%s_wr%0d", name, i), 64'(wq[i]), 64'({16'(i), img[i]}));
  endtask

  task automatic do_restart(input string name);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check({name, "_rs_ready"}, 64'(s_ready), 64'd1);
    check({name, "_rs_done"}, 64'(done), 64'd0);
    check({name, "_rs_error"}, 64'(error), 64'd0);
    check({name, "_rs_core"}, 64'(core_rst), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w5;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_core_rst", 64'(core_rst), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_s_ready", 64'(s_ready), 64'd1);

    // Two-word load with the documented byte stream.
    img.delete();
    img.push_back(32'h001000ab);
    img.push_back(32'h00119133);
    load_and_check("two", 2, 32'd0, 0);
    if (wq.size() == 2) check("two_w1_lit", 64'(wq[1]), 64'h0001_0011_9133);
    repeat (5) @(negedge clk);
    check("two_hold_ready", 64'(s_ready), 64'd0);
    check("two_hold_done", 64'(done), 64'd1);
    do_restart("two");

    // Same image, checksum 99 91 01 00 instead of 98 91 01 00.
    load_and_check("badcs", 2, 32'h00000001, 0);
    do_restart("badcs");

    // Oversize header, then restart and a valid load.
    load_and_check("over", 16'h0401, 32'd0, 0);
    do_restart("over");
    fill_img(3);
    load_and_check("after_over", 3, 32'd0, 1);
    do_restart("after_over");

    // Largest legal image fills every address.
    fill_img(DEPTH);
    load_and_check("full", DEPTH, 32'd0, 0);
    do_restart("full");

    // Empty images.
    img.delete();
    load_and_check("empty", 0, 32'd0, 0);
    do_restart("empty");
    load_and_check("empty_bad", 0, 32'h00000001, 0);
    do_restart("empty_bad");

    // Gapped 16-word load; restart toggles randomly and must be ignored.
    fill_img(16);
    noise_restart = 1'b1;
    load_and_check("gap16", 16, 32'd0, 3);
    noise_restart = 1'b0;
    do_restart("gap16");

    // Reset asserted after two bytes of word 5.
    fill_img(8);
    wq.delete();
    send_byte(8'd8, 0);
    send_byte(8'd0, 0);
    for (int i = 0; i < 5; i++) send_word(img[i], 1);
    w5 = img[5];
    send_byte(w5[7:0], 1);
    send_byte(w5[15:8], 1);
    #2 rst = 1'b0;
    #1;
    check("mid_s_ready", 64'(s_ready), 64'd0);
    check("mid_mem_we", 64'(mem_we), 64'd0);
    check("mid_mem_addr", 64'(mem_addr), 64'd0);
    check("mid_mem_wdata", 64'(mem_wdata), 64'd0);
    check("mid_core_rst", 64'(core_rst), 64'd0);
    check("mid_done", 64'(done), 64'd0);
    check("mid_error", 64'(error), 64'd0);
    check("mid_nwrites", 64'(wq.size()), 64'd5);
    for (int i = 0; i < 5 && i < wq.size(); i++)
      check($sformatf("mid_wr%0d", i), 64'(wq[i]), 64'({16'(i), img[i]}));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", 64'(s_ready), 64'd1);
    fill_img(16);
    load_and_check("reload", 16, 32'd0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
